// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory: a byte-stream loader fills a DEPTH-entry
// array, then the CPU fetches over a registered one-cycle-latency port with range checks.
module imem_loadable #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              prog_ready,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_W  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        READY
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W:0]   pointer;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              beat;
    logic              done;
    logic              fetch_go;
    logic [ADDR_W:0]   addr_ext;

    assign addr_ext = {1'b0, fetch_addr};

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        beat       = 1'b0;
        done       = 1'b0;
        fetch_go   = 1'b0;
        case (state)
            EMPTY: begin
                if (load_start) state_next = LOAD;
            end
            LOAD: begin
                // A restart drops any beat presented in the same cycle.
                if (!load_start && load_valid && load_ready) begin
                    beat = 1'b1;
                    if (load_last || pointer == LAST_W) begin
                        done       = 1'b1;
                        state_next = READY;
                    end
                end
            end
            READY: begin
                if (load_start) state_next = LOAD;
                else            fetch_go   = fetch_en;
            end
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pointer     <= '0;
            load_count  <= '0;
            load_ready  <= 1'b0;
            prog_ready  <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fetch_err   <= 1'b0;
        end else begin
            if (load_start) begin
                pointer    <= '0;
                load_count <= '0;
                prog_ready <= 1'b0;
                load_ready <= 1'b1;
            end else if (beat) begin
                pointer <= pointer + ONE_W;
                if (done) begin
                    load_count <= pointer + ONE_W;
                    load_ready <= 1'b0;
                    prog_ready <= 1'b1;
                end
            end

            fetch_valid <= fetch_go;
            // Result registers hold their last value when no fetch is serviced.
            if (fetch_go) begin
                if (addr_ext >= DEPTH_W) begin
                    fetch_instr <= '0;
                    fetch_err   <= 1'b1;
                end else if (addr_ext < load_count) begin
                    fetch_instr <= mem[fetch_addr[IDX_W-1:0]];
                    fetch_err   <= 1'b0;
                end else begin
                    fetch_instr <= '0;
                    fetch_err   <= 1'b0;
                end
            end
        end
    end

    // NOTE: the array has no reset; contents are meaningless until a load completes.
    always_ff @(posedge clk) begin
        if (beat) mem[pointer[IDX_W-1:0]] <= load_data;
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Randomized self-checking bench for imem_loadable against an array-based model of
// the loaded image, its entry count and the fetch range rules.
module tb_imem_loadable;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start, load_valid, load_last;
    logic [7:0] load_data;
    logic       load_ready;
    logic [8:0] load_count;
    logic       prog_ready;
    logic       fetch_en;
    logic [7:0] fetch_addr;
    logic       fetch_valid;
    logic [7:0] fetch_instr;
    logic       fetch_err;

    imem_loadable #(.DATA_W(8), .ADDR_W(8), .DEPTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_count (load_count),
        .prog_ready (prog_ready),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: image contents, programmed entry count, held fetch result.
    logic [7:0] ref_mem [32];
    int         ref_count;
    logic [7:0] ref_instr;
    logic       ref_err;
    logic [7:0] img2 [$];
    logic [7:0] img_r [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected fetch result from the range rules.
    task automatic model_fetch(input logic [7:0] a);
        ref_err   = (a >= 8'd32);
        ref_instr = (int'(a) < ref_count) ? ref_mem[a[4:0]] : 8'h00;
    endtask

    task automatic check_fetch_out(input string tag);
        check({tag, ".valid"}, 32'(fetch_valid), 32'd1);
        check({tag, ".instr"}, 32'(fetch_instr), 32'(ref_instr));
        check({tag, ".err"},   32'(fetch_err),   32'(ref_err));
    endtask

    task automatic fetch_one(input logic [7:0] a, input string tag);
        fetch_en = 1'b1; fetch_addr = a;
        tick();
        fetch_en = 1'b0;
        model_fetch(a);
        check_fetch_out(tag);
        tick();
        check({tag, ".drop"}, 32'(fetch_valid), 32'd0);
    endtask

    // Loads an image with random gaps; abort_at >= 0 asserts reset before that beat.
    task automatic load_image(input logic [7:0] img[$], input bit use_last, input int abort_at);
        int n = img.size();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        ref_count  = 0;
        check("ld.ready_on", 32'(load_ready), 32'd1);
        check("ld.prog_off", 32'(prog_ready), 32'd0);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 2) == 0) begin
                load_valid = 1'b0;
                tick();
            end
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                ref_count = 0; ref_instr = 8'h00; ref_err = 1'b0;
                check("abort.prog", 32'(prog_ready), 32'd0);
                check("abort.cnt",  32'(load_count), 32'd0);
                check("abort.lrdy", 32'(load_ready), 32'd0);
                load_valid = 1'b0;
                tick();
                rst_n = 1'b1;
                return;
            end
            load_valid = 1'b1;
            load_data  = img[i];
            load_last  = use_last && (i == n - 1);
            if (i < 32) ref_mem[i] = img[i];
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        ref_count = (n > 32) ? 32 : n;
        check("ld.count",    32'(load_count), 32'(ref_count));
        check("ld.prog_on",  32'(prog_ready), 32'd1);
        check("ld.ready_off", 32'(load_ready), 32'd0);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] first_word;
        rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 8'h00; fetch_en = 1'b1; fetch_addr = 8'h00;
        ref_count = 0; ref_instr = 8'h00; ref_err = 1'b0;
        img2 = '{8'h45, 8'h84, 8'h58, 8'h27, 8'h3A, 8'h3A, 8'h2D, 8'h85, 8'h4D, 8'h1E,
                 8'h44, 8'h1A, 8'h1A, 8'h1A, 8'h1A, 8'h6F, 8'h2D, 8'h69, 8'h2D, 8'hC1,
                 8'h00, 8'h45, 8'hEF};

        // 1. Reset state; fetch in EMPTY ignored.
        repeat (3) tick();
        check("rst.lrdy",  32'(load_ready),  32'd0);
        check("rst.cnt",   32'(load_count),  32'd0);
        check("rst.prog",  32'(prog_ready),  32'd0);
        check("rst.instr", 32'(fetch_instr), 32'd0);
        check("rst.err",   32'(fetch_err),   32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("empty.fvalid", 32'(fetch_valid), 32'd0);
        check("empty.instr",  32'(fetch_instr), 32'd0);
        fetch_en = 1'b0;

        // 2. Load the reference image with load_last.
        load_image(img2, 1'b1, -1);
        check("t2.count23", 32'(load_count), 32'd23);
        fetch_one(8'd0, "t2.a0");
        check("t2.a0_val", 32'(ref_instr), 32'h45);
        fetch_one(8'd22, "t2.a22");

        // 3. Back-to-back fetches.
        fetch_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            fetch_addr = 8'(i);
            tick();
            model_fetch(8'(i));
            check_fetch_out($sformatf("t3.b2b%0d", i));
        end
        fetch_en = 1'b0;
        tick();
        check("t3.drop", 32'(fetch_valid), 32'd0);

        // 4. Range checks.
        fetch_one(8'd23, "t4.a23");
        fetch_one(8'd31, "t4.a31");
        fetch_one(8'd40, "t4.a40");
        fetch_one(8'd255, "t4.a255");

        // 5. Full-array load without load_last, then a 33rd beat is refused.
        img_r.delete();
        for (int i = 0; i < 32; i++) img_r.push_back(8'($urandom));
        load_image(img_r, 1'b0, -1);
        first_word = img_r[0];
        load_valid = 1'b1; load_data = ~first_word; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        check("t5.cnt_hold",  32'(load_count), 32'd32);
        check("t5.prog_hold", 32'(prog_ready), 32'd1);
        check("t5.lrdy_hold", 32'(load_ready), 32'd0);
        fetch_one(8'd0,  "t5.a0");
        fetch_one(8'd31, "t5.a31");
        fetch_one(8'd32, "t5.a32");

        // 6a. Reset at beat 5 aborts the load; fetches ignored afterwards.
        img_r.delete();
        for (int i = 0; i < 12; i++) img_r.push_back(8'($urandom));
        load_image(img_r, 1'b1, 4);
        fetch_en = 1'b1; fetch_addr = 8'd0;
        tick();
        fetch_en = 1'b0;
        check("t6a.fvalid", 32'(fetch_valid), 32'd0);
        check("t6a.instr",  32'(fetch_instr), 32'd0);
        check("t6a.prog",   32'(prog_ready),  32'd0);
        check("t6a.cnt",    32'(load_count),  32'd0);

        // 6b. load_start with fetch_en in READY: fetch dropped, load proceeds.
        load_image(img2, 1'b1, -1);
        fetch_one(8'd5, "t6b.pre");
        load_start = 1'b1; fetch_en = 1'b1; fetch_addr = 8'd1;
        tick();
        load_start = 1'b0;
        check("t6b.fdrop", 32'(fetch_valid), 32'd0);
        check("t6b.lrdy",  32'(load_ready),  32'd1);
        check("t6b.prog",  32'(prog_ready),  32'd0);
        tick();
        fetch_en = 1'b0;
        check("t6b.ld_fv",    32'(fetch_valid), 32'd0);
        check("t6b.ld_instr", 32'(fetch_instr), 32'(ref_instr));

        // Random short image, then randomized fetches across all ranges.
        img_r.delete();
        for (int i = 0; i < int'($urandom_range(1, 31)); i++) img_r.push_back(8'($urandom));
        load_image(img_r, 1'b1, -1);
        for (int k = 0; k < 40; k++) begin
            a = 8'($urandom_range(0, 63));
            fetch_en = 1'b1; fetch_addr = a;
            tick();
            model_fetch(a);
            check_fetch_out($sformatf("rnd.a%0d", a));
        end
        fetch_en = 1'b0;
        tick();
        check("rnd.drop", 32'(fetch_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised, run-time loadable instruction memory. It replaces the fixed combinational 8-bit/32-entry program ROM. A byte-stream loader writes a program image into a DEPTH-entry array. The CPU then fetches over a registered, one-cycle-latency port with range checking. The block sits between the boot/debug loader and the CPU fetch stage.

Parameters:
DATA_W, 8, instruction width in bits.
ADDR_W, 8, fetch address width; DEPTH must be <= 2**ADDR_W.
DEPTH, 32, number of instruction entries.

Ports:
clk  in  1  single clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
load_start  in  1  pulse; begins a new program load at entry 0.
load_valid  in  1  load_data is valid this cycle.
load_data  in  DATA_W  instruction word to write.
load_last  in  1  qualifies the final beat of the image (sampled with load_valid).
load_ready  out  1  block accepts a load beat this cycle.
load_count  out  ADDR_W+1  number of entries written by the last completed load.
prog_ready  out  1  a program is loaded; fetches are serviced.
fetch_en  in  1  fetch request.
fetch_addr  in  ADDR_W  fetch address.
fetch_valid  out  1  fetch_instr/fetch_err are valid this cycle.
fetch_instr  out  DATA_W  fetched instruction.
fetch_err  out  1  fetch_addr was >= DEPTH.

Behaviour:
- FSM states:
  - EMPTY: entered on reset; no program loaded.
  - LOAD: accepting load beats.
  - READY: program loaded; fetches serviced.
- Reset (rst_n low, asynchronous):
  - state=EMPTY; write pointer=0; load_count=0.
  - load_ready=0, prog_ready=0, fetch_valid=0, fetch_instr=0, fetch_err=0.
  - Array contents are not reset and are don't-care until the next load.
- EMPTY/READY -> LOAD on load_start:
  - pointer <= 0; load_count <= 0; prog_ready <= 0.
- In LOAD:
  - load_ready=1 (registered, high from the cycle after load_start).
  - A beat is load_valid & load_ready. It writes mem[pointer] <= load_data, then pointer++.
  - Gaps (load_valid=0) are allowed and write nothing.
- LOAD -> READY when either:
  - a beat has load_last=1, or
  - a beat writes entry DEPTH-1 (array full; load_last is ignored).
  - On that transition: load_count <= pointer+1; load_ready <= 0; prog_ready <= 1.
- load_start while in LOAD restarts the load at pointer 0; the concurrent beat, if any, is dropped.
- Fetch, READY only:
  - fetch_en in cycle N gives fetch_valid=1 in cycle N+1 for exactly one cycle.
  - Throughput is one fetch per cycle; back-to-back requests give consecutive valid cycles.
- Fetch result, by fetch_addr:
  - < load_count: fetch_instr = mem[addr], fetch_err=0.
  - >= load_count and < DEPTH (unprogrammed): fetch_instr=0 (NOP), fetch_err=0.
  - >= DEPTH: fetch_instr=0, fetch_err=1.
- fetch_en in EMPTY or LOAD is ignored: fetch_valid stays 0 and fetch_instr holds its last value.
- load_start and fetch_en in the same cycle while READY: load has priority; the fetch is dropped and fetch_valid=0 in N+1.
- Read-during-write cannot occur, since no fetch is serviced during LOAD.
- Address arithmetic is unsigned.
- pointer and load_count are ADDR_W+1 bits wide, so DEPTH=2**ADDR_W is representable.
- Reset during LOAD aborts immediately: EMPTY, load_count=0. The partial image is unusable until a new load completes.

Test Plan:
1. Reset check: hold rst_n=0, then release. Required: all outputs 0 and state EMPTY. fetch_en=1 with addr 0 gives fetch_valid=0.
2. Load the 23-byte image 0x45,0x84,0x58,0x27,0x3A,0x3A,0x2D,0x85,0x4D,0x1E,0x44,0x1A,0x1A,0x1A,0x1A,0x6F,0x2D,0x69,0x2D,0xC1,0x00,0x45,0xEF, with load_last on beat 23 and random load_valid gaps. Required: load_count=23, prog_ready=1. Fetch addr 0 gives 0x45 next cycle; addr 22 gives 0xEF.
3. Back-to-back fetch of addr 1,2,3 on consecutive cycles. Required: fetch_valid high for 3 consecutive cycles carrying 0x84, 0x58, 0x27. Deassert fetch_en: fetch_valid drops the next cycle.
4. Range checks after test 2:
   - addr 23 gives instr 0x00, err 0.
   - addr 31 gives instr 0x00, err 0.
   - addr 40 gives instr 0x00, err 1.
5. Full-array load of 32 beats without load_last. Required: auto-transition to READY after beat 32, load_count=32, load_ready=0 the following cycle; a 33rd load_valid is not accepted.
6. Interrupted load and restart:
   - Assert rst_n=0 at beat 5 of a load. Required: prog_ready=0, load_count=0, fetches ignored.
   - Separately, assert load_start together with fetch_en in READY. Required: fetch dropped, load_ready=1 the next cycle.
